// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI data-island packet path.
package hdmi_pkg;

  localparam logic [7:0] BCH_POLY      = 8'h83;
  localparam int         PACKET_SLICES = 32;

  typedef logic [55:0] sub_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // One serial BCH step, input bit entering at the LSB end.
  function automatic logic [7:0] ecc_step(logic [7:0] e, logic b);
    return {1'b0, e[7:1]} ^ ((e[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/hdmi_bch_ecc8.sv
// Serial BCH(8) engine: absorbs BITS data bits per cycle, then shifts the
// finished ECC out LSB-first, BITS per cycle.
module hdmi_bch_ecc8
  import hdmi_pkg::*;
#(
  parameter int BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_absorb,
  input  logic            i_shift,
  input  logic [BITS-1:0] i_bits,
  output logic [BITS-1:0] o_bits
);

  logic [7:0] r_ecc;
  logic [7:0] w_nxt;

  // i_clr restarts from zero so a new packet's first bits see a clean engine.
  always_comb begin
    w_nxt = i_clr ? 8'h00 : r_ecc;
    if (i_absorb) begin
      for (int b = 0; b < BITS; b++) w_nxt = ecc_step(w_nxt, i_bits[b]);
    end else if (i_shift) begin
      w_nxt = w_nxt >> BITS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ecc <= 8'h00;
    else        r_ecc <= w_nxt;
  end

  assign o_bits = r_ecc[BITS-1:0];

endmodule

// File: rtl/hdmi_packet_serializer.sv
// Serializes a 24-bit header and four 56-bit subpackets into 32 data-island
// slices, appending BCH ECC computed on the fly.
module hdmi_packet_serializer
  import hdmi_pkg::*;
(
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [23:0] header,
  input  sub_t [3:0]  sub,
  output logic        data_valid,
  output logic        data_first,
  output logic        data_last,
  output logic [8:0]  packet_data
);

  localparam logic [4:0] LAST     = 5'(PACKET_SLICES - 1);
  localparam logic [4:0] HDR_BITS = 5'd24;
  localparam logic [4:0] SUB_PAIR = 5'd28;

  ser_state_t r_state, w_state;
  logic [4:0]  r_n, w_n, w_m;
  logic        r_ready, w_ready, r_valid, w_valid;
  logic        r_first, w_first, r_last, w_last;
  logic [8:0]  r_data, w_data;
  logic [23:0] r_hdr, w_hdr;
  sub_t [3:0]  r_sub, w_sub;
  logic        w_acc, w_go;

  logic        w_h_absorb, w_h_shift, w_h_in, w_h_ecc, w_hbit;
  logic        w_s_absorb, w_s_shift;
  logic [3:0][1:0] w_s_in, w_s_ecc, w_sbits;

  // w_m is the slice index the registers will present after this edge.
  always_comb begin
    w_acc = pkt_valid & r_ready;
    w_go  = w_acc | ((r_state == ST_SEND) && (r_n != LAST));
    w_m   = w_acc ? 5'd0 : r_n + 5'd1;
    w_hdr = w_acc ? header : r_hdr;
    w_sub = w_acc ? sub : r_sub;
  end

  always_comb begin
    w_h_absorb = w_go && (w_m < HDR_BITS);
    w_h_shift  = w_go && (w_m >= HDR_BITS);
    w_h_in     = (w_m < HDR_BITS) ? w_hdr[w_m] : 1'b0;
    w_hbit     = w_h_absorb ? w_h_in : w_h_ecc;
    w_s_absorb = w_go && (w_m < SUB_PAIR);
    w_s_shift  = w_go && (w_m >= SUB_PAIR);
    for (int k = 0; k < 4; k++) begin
      w_s_in[k]  = (w_m < SUB_PAIR) ? w_sub[k][{w_m, 1'b0} +: 2] : 2'b00;
      w_sbits[k] = w_s_absorb ? w_s_in[k] : w_s_ecc[k];
    end
  end

  hdmi_bch_ecc8 #(.BITS(1)) u_hdr_ecc (
    .clk      (clk_pixel),
    .rst_n    (reset_n),
    .i_clr    (w_acc),
    .i_absorb (w_h_absorb),
    .i_shift  (w_h_shift),
    .i_bits   (w_h_in),
    .o_bits   (w_h_ecc)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
    hdmi_bch_ecc8 #(.BITS(2)) u_sub_ecc (
      .clk      (clk_pixel),
      .rst_n    (reset_n),
      .i_clr    (w_acc),
      .i_absorb (w_s_absorb),
      .i_shift  (w_s_shift),
      .i_bits   (w_s_in[k]),
      .o_bits   (w_s_ecc[k])
    );
  end

  always_comb begin
    w_state = ST_IDLE;
    w_n     = 5'd0;
    w_ready = 1'b1;
    w_valid = 1'b0;
    w_first = 1'b0;
    w_last  = 1'b0;
    w_data  = 9'd0;
    if (w_go) begin
      w_state = ST_SEND;
      w_n     = w_m;
      w_ready = (w_m == LAST);
      w_valid = 1'b1;
      w_first = (w_m == 5'd0);
      w_last  = (w_m == LAST);
      w_data  = {w_sbits[3][1], w_sbits[2][1], w_sbits[1][1], w_sbits[0][1],
                 w_sbits[3][0], w_sbits[2][0], w_sbits[1][0], w_sbits[0][0],
                 w_hbit};
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_n     <= 5'd0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= 9'd0;
      r_hdr   <= 24'd0;
      r_sub   <= '0;
    end else begin
      r_state <= w_state;
      r_n     <= w_n;
      r_ready <= w_ready;
      r_valid <= w_valid;
      r_first <= w_first;
      r_last  <= w_last;
      r_data  <= w_data;
      if (w_acc) begin
        r_hdr <= header;
        r_sub <= sub;
      end
    end
  end

  assign pkt_ready   = r_ready;
  assign data_valid  = r_valid;
  assign data_first  = r_first;
  assign data_last   = r_last;
  assign packet_data = r_data;

endmodule
